chirq: RTL

Channel-side interrupt reporter. It sits directly upstream of the CPU interrupt unit (P-P). It collects interrupt requests from 16 I/O channels into a pending register and picks the highest-priority one. It then delivers that request to the CPU as a bus "IN" transfer: rin_ strobe, channel number on rdt11_..rdt14_, rdt15_ low as the interrupt marker. The P-P unit accepts the transfer with dok_, which latches the request into its RZ channel bits 12–27.

---
 rtl/chirq_pkg.sv | 16 +
 rtl/chirq_prio16.sv | 22 ++
 rtl/chirq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/chirq_pkg.sv
// rtl/chirq_pkg.sv - shared types and constants for the channel interrupt reporter
package chirq_pkg;

    // Width of a channel number on the bus (16 channels)
    localparam int CHAN_W = 4;

    // Transfer sequencer states
    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        REQ,
        RELEASE,
        BACKOFF
    } state_e;

endpackage

// File: rtl/chirq_prio16.sv
// rtl/chirq_prio16.sv - lowest-index-first priority encoder over 16 pending bits
module chirq_prio16
    import chirq_pkg::*;
(
    input  logic [0:15]       vec_i,
    output logic [CHAN_W-1:0] idx_o,
    output logic              valid_o
);

    // Scan from the top down so the lowest set index is the last one written
    always_comb begin
        idx_o   = '0;
        valid_o = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            if (vec_i[i]) begin
                idx_o   = CHAN_W'(i);
                valid_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/chirq.sv
// rtl/chirq.sv - collects channel interrupt requests and delivers them to P-P as bus IN transfers
module chirq
    import chirq_pkg::*;
#(
    parameter int SETUP_TICKS   = 2,
    parameter int TIMEOUT_TICKS = 64,
    parameter int BACKOFF_TICKS = 8,
    parameter int MAX_RETRY     = 3
) (
    input  logic              __clk,
    input  logic              clm,
    input  logic [0:15]       req,
    input  logic              dok_,
    output logic              rin_,
    output logic [11:15]      rdt_,
    output logic              rdt0_,
    output logic [0:15]       pend,
    output logic              busy,
    output logic              err,
    output logic [CHAN_W-1:0] err_chan
);

    localparam int MAX_ST = (SETUP_TICKS > BACKOFF_TICKS) ? SETUP_TICKS : BACKOFF_TICKS;
    localparam int MAX_T  = (TIMEOUT_TICKS > MAX_ST) ? TIMEOUT_TICKS : MAX_ST;
    localparam int TW     = $clog2(MAX_T + 1);
    localparam int RW     = $clog2(MAX_RETRY + 1);

    // Terminal counts: each phase lasts exactly its tick count in cycles
    localparam logic [TW-1:0] SETUP_LAST   = TW'(SETUP_TICKS - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_TICKS - 1);
    localparam logic [TW-1:0] BACKOFF_LAST = TW'(BACKOFF_TICKS - 1);
    localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRY);

    state_e              state_q, state_d;
    logic [CHAN_W-1:0]   cur_q, cur_d;
    logic [TW-1:0]       tick_q, tick_d;
    logic [RW-1:0]       retry_q, retry_d;
    logic [0:15]         pend_q, pend_d;
    logic                err_q, err_d;
    logic [CHAN_W-1:0]   err_chan_q, err_chan_d;

    logic                clr_en;
    logic [0:15]         clr_mask;
    logic [RW-1:0]       retry_inc;
    logic [CHAN_W-1:0]   prio_idx;
    logic                prio_valid;
    logic                drive;

    chirq_prio16 u_prio (
        .vec_i   (pend_q),
        .idx_o   (prio_idx),
        .valid_o (prio_valid)
    );

    // Saturating increment of the timeout count
    assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + RW'(1);

    // Sequencer next state: arbitration, setup, request window, release, backoff
    always_comb begin
        state_d    = state_q;
        cur_d      = cur_q;
        tick_d     = tick_q;
        retry_d    = retry_q;
        err_d      = 1'b0;
        err_chan_d = err_chan_q;
        clr_en     = 1'b0;
        case (state_q)
            IDLE: begin
                if (prio_valid) begin
                    cur_d   = prio_idx;
                    tick_d  = '0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (tick_q == SETUP_LAST) begin
                    tick_d  = '0;
                    state_d = REQ;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            REQ: begin
                // Acceptance is checked first so it beats a coincident timeout
                if (!dok_) begin
                    clr_en  = 1'b1;
                    retry_d = '0;
                    state_d = RELEASE;
                end else if (tick_q == TIMEOUT_LAST) begin
                    tick_d = '0;
                    if (retry_inc == RETRY_MAX) begin
                        clr_en     = 1'b1;
                        err_d      = 1'b1;
                        err_chan_d = cur_q;
                        retry_d    = '0;
                        state_d    = IDLE;
                    end else begin
                        retry_d = retry_inc;
                        state_d = BACKOFF;
                    end
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            RELEASE: begin
                if (dok_) begin
                    state_d = IDLE;
                end
            end
            BACKOFF: begin
                // cur is kept; the same channel is retried without re-arbitrating
                if (tick_q == BACKOFF_LAST) begin
                    tick_d  = '0;
                    state_d = SETUP;
                end else begin
                    tick_d = tick_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Pending update: clear the finished channel, new requests override the clear
    always_comb begin
        clr_mask = '0;
        for (int i = 0; i < 16; i++) begin
            clr_mask[i] = clr_en && (cur_q == CHAN_W'(i));
        end
        pend_d = (pend_q & ~clr_mask) | req;
    end

    // State registers with synchronous master clear
    always_ff @(posedge __clk) begin
        if (clm) begin
            state_q    <= IDLE;
            cur_q      <= '0;
            tick_q     <= '0;
            retry_q    <= '0;
            pend_q     <= '0;
            err_q      <= 1'b0;
            err_chan_q <= '0;
        end else begin
            state_q    <= state_d;
            cur_q      <= cur_d;
            tick_q     <= tick_d;
            retry_q    <= retry_d;
            pend_q     <= pend_d;
            err_q      <= err_d;
            err_chan_q <= err_chan_d;
        end
    end

    // Bus drive follows the registered state; BACKOFF and IDLE float all lines high
    always_comb begin
        drive          = (state_q == SETUP) || (state_q == REQ) || (state_q == RELEASE);
        rin_           = (state_q != REQ);
        rdt_[11:14]    = drive ? ~cur_q : 4'hF;
        rdt_[15]       = ~drive;
        rdt0_          = 1'b1;
        busy           = (state_q != IDLE);
        pend           = pend_q;
        err            = err_q;
        err_chan       = err_chan_q;
    end

endmodule
